// File: rtl/comparator_seq_ctrl.sv
// Wide unsigned magnitude compare done one nibble per cycle, MSB nibble first.
// Define CMP_EARLY_EXIT_EN to stop at the first differing nibble instead of always scanning all nibbles.
module comparator_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] A,
    input  logic [4*NIBBLES-1:0] B,
    output logic                 busy,
    output logic                 done,
    output logic                 A_great_B,
    output logic                 A_equal_B,
    output logic                 A_less_B
);

    localparam int IDX_W = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [4*NIBBLES-1:0] a_reg;
    logic [4*NIBBLES-1:0] b_reg;
    logic [IDX_W-1:0]     idx;
    logic [3:0]           a_nib;
    logic [3:0]           b_nib;
    logic                 nib_gt;
    logic                 nib_lt;
    logic                 decided;
    logic                 last_nib;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The single shared 4-bit compare stage looks at whichever nibble idx selects.
    always_comb begin
        a_nib   = a_reg[{idx, 2'b00} +: 4];
        b_nib   = b_reg[{idx, 2'b00} +: 4];
        nib_gt  = a_nib > b_nib;
        nib_lt  = a_nib < b_nib;
        decided = A_great_B | A_less_B;
`ifdef CMP_EARLY_EXIT_EN
        last_nib = (idx == '0) || nib_gt || nib_lt;
`else
        last_nib = (idx == '0);
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = CMP;
            CMP:  if (last_nib) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Once a differing nibble has set a flag, lower nibbles are only walked for fixed timing.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            idx       <= '0;
            A_great_B <= 1'b0;
            A_equal_B <= 1'b0;
            A_less_B  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg     <= A;
                        b_reg     <= B;
                        idx       <= IDX_W'(NIBBLES - 1);
                        A_great_B <= 1'b0;
                        A_equal_B <= 1'b0;
                        A_less_B  <= 1'b0;
                    end
                end
                CMP: begin
                    if (!decided) begin
                        if (nib_gt) begin
                            A_great_B <= 1'b1;
                        end else if (nib_lt) begin
                            A_less_B <= 1'b1;
                        end else if (idx == '0) begin
                            A_equal_B <= 1'b1;
                        end
                    end
                    if (idx != '0) begin
                        idx <= idx - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
